keypad_col_scanner: RTL and testbench

// - Column-drive side of the 4x4 hex keypad. Drives col[3:0] and watches the

---
 rtl/keypad_pkg.sv | 8 +
 rtl/keypad_cycle_timer.sv | 18 +
 rtl/keypad_col_scanner.sv | 106 ++++++++++
 tb/tb_keypad_col_scanner.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad geometry and scanner state encoding.
package keypad_pkg;
  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int CODE_W = 4;
  localparam int IDX_W = 2;
  typedef enum logic [2:0] {IDLE, DEBOUNCE, SCAN, DETECT, HELD} state_t;
endpackage

// File: rtl/keypad_cycle_timer.sv
// keypad_cycle_timer: saturating cycle counter with clear, enable and terminal-count flag.
module keypad_cycle_timer #(
  parameter int LIMIT = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);
  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  logic [W-1:0] r_cnt;
  assign o_tc = (r_cnt == W'(LIMIT - 1));
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_en && !o_tc) r_cnt <= r_cnt + W'(1);
endmodule

// File: rtl/keypad_col_scanner.sv
// keypad_col_scanner: debounces a keypad press, walks the columns one-hot and
// emits the hex key code with a single-cycle valid pulse.
module keypad_col_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_s_row,
  input  logic [NUM_ROWS-1:0] i_row,
  output logic [NUM_COLS-1:0] o_col,
  output logic [CODE_W-1:0]   o_code,
  output logic                o_valid,
  output logic                o_multi_key,
  output logic                o_key_down
);
  state_t              r_state, w_next;
  logic [IDX_W-1:0]    r_col_idx, w_row_idx;
  logic [NUM_ROWS-1:0] r_row_s1, r_row_q;
  logic [CODE_W-1:0]   r_code;
  logic [2:0]          w_row_cnt;
  logic r_valid, r_multi, r_key_down;
  logic w_deb_en, w_deb_tc, w_set_en, w_set_clr, w_set_tc, w_col_adv, w_hit, w_multi;

  // One timer debounces both press (s_row high) and release (s_row low).
  assign w_deb_en = (r_state == DEBOUNCE && i_s_row) || (r_state == HELD && !i_s_row);
  assign w_set_en = (r_state == SCAN);
  assign w_set_clr = !w_set_en || w_set_tc;

  keypad_cycle_timer #(.LIMIT(DEBOUNCE_CYCLES)) u_debounce (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_clear(!w_deb_en),
    .i_en   (w_deb_en),
    .o_tc   (w_deb_tc)
  );

  keypad_cycle_timer #(.LIMIT(SETTLE_CYCLES)) u_settle (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_clear(w_set_clr),
    .i_en   (w_set_en),
    .o_tc   (w_set_tc)
  );

  always_comb begin
    w_row_idx = '0;
    w_row_cnt = '0;
    for (int i = 0; i < NUM_ROWS; i++)
      if (r_row_q[i]) begin
        w_row_idx = IDX_W'(i);
        w_row_cnt = w_row_cnt + 3'd1;
      end
  end

  assign w_hit   = (r_state == DETECT) && (w_row_cnt == 3'd1);
  assign w_multi = (r_state == DETECT) && (w_row_cnt > 3'd1);

  always_comb begin
    w_next = r_state;
    w_col_adv = 1'b0;
    case (r_state)
      IDLE:     w_next = i_s_row ? DEBOUNCE : IDLE;
      DEBOUNCE: w_next = !i_s_row ? IDLE : (w_deb_tc ? SCAN : DEBOUNCE);
      SCAN:
        if (w_set_tc) begin
          if (i_s_row) w_next = DETECT;
          else if (r_col_idx == IDX_W'(NUM_COLS - 1)) w_next = IDLE;
          else w_col_adv = 1'b1;
        end
      DETECT:   w_next = (r_row_q == '0) ? IDLE : HELD;
      HELD:     w_next = (!i_s_row && w_deb_tc) ? IDLE : HELD;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_state    <= IDLE;
      r_col_idx  <= '0;
      r_row_s1   <= '0;
      r_row_q    <= '0;
      r_code     <= '0;
      r_valid    <= 1'b0;
      r_multi    <= 1'b0;
      r_key_down <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_row_s1   <= i_row;
      r_row_q    <= r_row_s1;
      r_col_idx  <= (r_state == SCAN) ? r_col_idx + IDX_W'(w_col_adv) : '0;
      r_valid    <= w_hit;
      r_multi    <= w_multi;
      r_key_down <= w_hit || (r_key_down && w_next != IDLE);
      if (w_hit) r_code <= {w_row_idx, r_col_idx};
    end

  // The column stays driven through DETECT so row_q still reflects the hit column.
  assign o_col       = (r_state == SCAN || r_state == DETECT) ? NUM_COLS'(1) << r_col_idx : '1;
  assign o_code      = r_code;
  assign o_valid     = r_valid;
  assign o_multi_key = r_multi;
  assign o_key_down  = r_key_down;
endmodule

// File: tb/tb_keypad_col_scanner.sv
// tb_keypad_col_scanner: keypad matrix model driving the scanner, checked against
// press/release timing and key-code rules.
module tb_keypad_col_scanner;
  localparam int SET = 4;
  localparam int DEB = 16;
  localparam int SYNC = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] pressed = '0;
  logic [3:0] row, col, code;
  logic [2:0] sr = '0;
  logic valid, multi, key_down;
  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  int n_valid = 0, n_multi = 0, n_both = 0, n_kd_rise = 0;
  int t_valid = -1, t_multi = -1, t_kd_rise = -1, t_kd_fall = -1, got_code = 0;
  logic kd_prev = 1'b0;
  int exp_code = 0;

  always #5 clk = ~clk;

  keypad_col_scanner #(.SETTLE_CYCLES(SET), .DEBOUNCE_CYCLES(DEB)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_s_row    (sr[2]),
    .i_row      (row),
    .o_col      (col),
    .o_code     (code),
    .o_valid    (valid),
    .o_multi_key(multi),
    .o_key_down (key_down)
  );

  // Key k sits at row k/4, column k%4; a row reads high when any pressed key in it is driven.
  always_comb begin
    row = '0;
    for (int r = 0; r < 4; r++) row[r] = |(pressed[4*r +: 4] & col);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    sr  <= {sr[1:0], |row};
  end

  always @(negedge clk) begin
    if (valid) begin
      n_valid <= n_valid + 1;
      t_valid <= cyc;
      got_code <= int'(code);
    end
    if (multi) begin
      n_multi <= n_multi + 1;
      t_multi <= cyc;
    end
    if (valid && multi) n_both <= n_both + 1;
    if (key_down && !kd_prev) begin
      n_kd_rise <= n_kd_rise + 1;
      t_kd_rise <= cyc;
    end
    if (!key_down && kd_prev) t_kd_fall <= cyc;
    kd_prev <= key_down;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Press a key set, hold it until extra cycles past the expected result, release cleanly.
  task automatic press(input string tag, input logic [15:0] mask, input int extra);
    int p, rel, hit_c, nrows, hit_r, t_ev, bv, bm, bk;
    hit_c = -1;
    nrows = 0;
    hit_r = 0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (hit_c < 0 && mask[4*r+c]) hit_c = c;
    for (int r = 0; r < 4; r++)
      if (mask[4*r+hit_c]) begin
        nrows++;
        hit_r = r;
      end
    @(negedge clk);
    bv = n_valid;
    bm = n_multi;
    bk = n_kd_rise;
    p = cyc;
    pressed = mask;
    t_ev = p + SYNC + DEB + SET * (hit_c + 1) + 2;
    repeat (t_ev - p + extra) @(negedge clk);
    rel = cyc;
    pressed = '0;
    repeat (SYNC + DEB + 8) @(negedge clk);
    if (nrows == 1) begin
      chk({tag, " valid_count"}, n_valid - bv, 1);
      chk({tag, " valid_time"}, t_valid, t_ev);
      chk({tag, " code"}, got_code, 4 * hit_r + hit_c);
      chk({tag, " multi_count"}, n_multi - bm, 0);
      chk({tag, " keydown_rise"}, t_kd_rise, t_ev);
      chk({tag, " keydown_fall"}, t_kd_fall, rel + SYNC + DEB);
      exp_code = 4 * hit_r + hit_c;
    end else begin
      chk({tag, " multi_count"}, n_multi - bm, 1);
      chk({tag, " multi_time"}, t_multi, t_ev);
      chk({tag, " valid_count"}, n_valid - bv, 0);
      chk({tag, " code_held"}, int'(code), exp_code);
      chk({tag, " keydown_rises"}, n_kd_rise - bk, 0);
    end
  endtask

  initial begin
    int bv, bm, bk, r2, k;
    logic [15:0] m;
    repeat (3) @(negedge clk);
    chk("rst col", int'(col), 15);
    chk("rst code", int'(code), 0);
    chk("rst valid", int'(valid), 0);
    chk("rst multi", int'(multi), 0);
    chk("rst key_down", int'(key_down), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    press("key5", 16'h0020, 10);
    press("keyF", 16'h8000, 10);

    bv = n_valid; bm = n_multi; bk = n_kd_rise;
    pressed = 16'h0020;
    repeat (10) @(negedge clk);
    pressed = '0;
    repeat (40) @(negedge clk);
    chk("bounce valid", n_valid - bv, 0);
    chk("bounce multi", n_multi - bm, 0);
    chk("bounce key_down", n_kd_rise - bk, 0);

    press("two_col2", 16'h0404, 10);
    press("hold500", 16'h0001, 500);

    bv = n_valid;
    pressed = 16'h0001;
    repeat (40) @(negedge clk);
    pressed = '0;
    repeat (8) @(negedge clk);
    pressed = 16'h0001;
    repeat (5) @(negedge clk);
    r2 = cyc;
    pressed = '0;
    repeat (40) @(negedge clk);
    chk("glitch valid_count", n_valid - bv, 1);
    chk("glitch keydown_fall", t_kd_fall, r2 + SYNC + DEB);

    for (int i = 0; i < 12; i++) begin
      m = 16'(1) << $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) m = m | (16'(1) << $urandom_range(0, 15));
      press($sformatf("rand%0d_%04h", i, m), m, $urandom_range(5, 60));
    end

    bv = n_valid;
    pressed = 16'h8000;
    k = 0;
    while (col != 4'b0100 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach col2", int'(col), 4);
    rst = 1'b1;
    #1;
    chk("midscan rst col", int'(col), 15);
    chk("midscan rst code", int'(code), 0);
    chk("midscan rst valid", int'(valid), 0);
    chk("midscan rst multi", int'(multi), 0);
    chk("midscan rst key_down", int'(key_down), 0);
    pressed = '0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("post rst valid", n_valid - bv, 0);
    chk("no valid+multi overlap", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
